// File: rtl/r2sdf_seq_ctrl_if.sv
// Handshake and control bundle between the sample source, the R2SDF
// sequencer and the butterfly stages. The master modport belongs to the
// upstream source, and the slave modport belongs to the sequencer.
// Optional macro SEQ_FRAME_CNT_EN adds the 16-bit frame_cnt signal.
interface r2sdf_seq_ctrl_if #(
  parameter int N = 3
);
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic           adv;
  logic           ip_zero;
  logic [N*N-1:0] stage_cnt;
  logic [N-1:0]   bf_sel;
  logic           out_valid;
  logic           out_first;
  logic           out_last;
  logic           frame_err;
`ifdef SEQ_FRAME_CNT_EN
  logic [15:0]    frame_cnt;
`endif

  modport master (
    output in_valid, in_last,
    input  in_ready, adv, ip_zero, stage_cnt, bf_sel,
`ifdef SEQ_FRAME_CNT_EN
    input  frame_cnt,
`endif
    input  out_valid, out_first, out_last, frame_err
  );

  modport slave (
    input  in_valid, in_last,
    output in_ready, adv, ip_zero, stage_cnt, bf_sel,
`ifdef SEQ_FRAME_CNT_EN
    output frame_cnt,
`endif
    output out_valid, out_first, out_last, frame_err
  );
endinterface

// File: rtl/r2sdf_seq_ctrl.sv
// Frame sequencer for a radix-2 single-delay-feedback FFT pipeline.
// It accepts samples, produces the common stage advance enable, and keeps
// per-stage sample counts. After the final frame, it drains the pipeline
// with zero bubbles and tags each output sample as valid, first or last.
// Optional macro SEQ_FRAME_CNT_EN adds a 16-bit count of completed output frames.
module r2sdf_seq_ctrl #(
  parameter int N = 3
) (
  input logic             clk,
  input logic             rst_n,
  r2sdf_seq_ctrl_if.slave bus
);
  localparam int F = 1 << N;
  localparam int L = F - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t       state;
  state_t       state_nxt;
  logic         rdy_q;
  logic [N-1:0] idx;
  logic [L:1]   tag_v;
  logic [L:1]   tag_f;
  logic [L:1]   tag_l;
  logic [N-1:0] cnt [N];
  logic         acc;
  logic         idx_last;
  logic         last_smp;
  logic         adv_c;
  logic         ip_zero_c;

  // Position 0 of the tag chain is the live accept. Positions 1..L are registered.
  assign acc      = bus.in_valid & rdy_q;
  assign idx_last = (idx == {N{1'b1}});
  assign last_smp = acc & (bus.in_last | idx_last);

  // Next-state and advance decode: the pipeline freezes on gaps unless it is draining.
  always_comb begin
    state_nxt = state;
    adv_c     = acc;
    ip_zero_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (acc) state_nxt = last_smp ? DRAIN : RUN;
      end
      RUN: begin
        if (last_smp) state_nxt = DRAIN;
      end
      DRAIN: begin
        adv_c     = 1'b1;
        ip_zero_c = ~acc;
        if (acc) state_nxt = last_smp ? DRAIN : RUN;
        else if (~|tag_v[L-1:1]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, accept-ready flag and in-frame sample index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= 1'b1;
      if (acc) idx <= last_smp ? '0 : idx + 1'b1;
    end
  end

  // In-flight tag chain. It shifts only when the whole pipeline advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_f <= '0;
      tag_l <= '0;
    end else if (adv_c) begin
      tag_v <= {tag_v[L-1:1], acc};
      tag_f <= {tag_f[L-1:1], acc & (idx == '0)};
      tag_l <= {tag_l[L-1:1], last_smp};
    end
  end

  // Each stage counts the advances on which a real sample reaches its input.
  for (genvar g = 0; g < N; g++) begin : g_stage
    logic inc;
    if (g == 0) begin : g_first
      assign inc = adv_c & acc;
    end else begin : g_later
      localparam int D = F - (1 << (N - g));
      assign inc = adv_c & tag_v[D];
    end

    // Local sample counter for stage g+1. It wraps naturally modulo F.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt[g] <= '0;
      else if (inc) cnt[g] <= cnt[g] + 1'b1;
    end

    assign bus.stage_cnt[g*N +: N] = cnt[g];
    assign bus.bf_sel[g]           = cnt[g][N-1-g];
  end

  assign bus.in_ready  = rdy_q;
  assign bus.adv       = adv_c;
  assign bus.ip_zero   = ip_zero_c;
  assign bus.out_valid = adv_c & tag_v[L];
  assign bus.out_first = adv_c & tag_v[L] & tag_f[L];
  assign bus.out_last  = adv_c & tag_v[L] & tag_l[L];
  assign bus.frame_err = acc & (bus.in_last ^ idx_last);

`ifdef SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed output frames, counted at each last-sample exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else if (adv_c & tag_v[L] & tag_l[L]) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_r2sdf_seq_ctrl.sv
// Directed bench for r2sdf_seq_ctrl with N=3 (F=8, L=7).
// Each test replays a cycle-indexed valid/last pattern and compares the
// recorded per-cycle output masks against hand-derived constants.
module tb_r2sdf_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [63:0] obs_adv, obs_ipz, obs_ov, obs_of, obs_ol, obs_fe;
  logic [8:0]  obs_stage [64];
  logic [2:0]  obs_bf [64];

  r2sdf_seq_ctrl_if #(.N(3)) bus ();

  r2sdf_seq_ctrl #(.N(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Reset, then release on a falling edge, then pass one rising edge so that in_ready is high.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drive cycle c with vmask[c]/lmask[c] and record the outputs at the falling edge.
  task automatic run_trace(input logic [63:0] vmask, input logic [63:0] lmask, input int ncyc);
    obs_adv = '0; obs_ipz = '0; obs_ov = '0; obs_of = '0; obs_ol = '0; obs_fe = '0;
    for (int c = 0; c < ncyc; c++) begin
      bus.in_valid = vmask[c];
      bus.in_last  = lmask[c];
      @(negedge clk);
      obs_adv[c]   = bus.adv;
      obs_ipz[c]   = bus.ip_zero;
      obs_ov[c]    = bus.out_valid;
      obs_of[c]    = bus.out_first;
      obs_ol[c]    = bus.out_last;
      obs_fe[c]    = bus.frame_err;
      obs_stage[c] = bus.stage_cnt;
      obs_bf[c]    = bus.bf_sel;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.adv !== 1'b0) begin n_err++; $display("[TB] FAIL reset adv: got %b want 0", bus.adv); end
    n_cmp++; if ({bus.ip_zero, bus.out_valid, bus.out_first, bus.out_last, bus.frame_err} !== 5'b0) begin
      n_err++; $display("[TB] FAIL reset flags: got %b want 00000", {bus.ip_zero, bus.out_valid, bus.out_first, bus.out_last, bus.frame_err}); end
    n_cmp++; if (bus.stage_cnt !== 9'd0 || bus.bf_sel !== 3'd0) begin
      n_err++; $display("[TB] FAIL reset stage: got %0d/%b want 0/000", bus.stage_cnt, bus.bf_sel); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL release in_ready early: got %b want 0", bus.in_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL release in_ready: got %b want 1", bus.in_ready); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_single_frame();
    do_reset();
    run_trace(64'hFF, 64'h80, 32);
    n_cmp++; if (obs_adv !== 64'h7FFF) begin n_err++; $display("[TB] FAIL frame adv: got %h want %h", obs_adv, 64'h7FFF); end
    n_cmp++; if (obs_ipz !== 64'h7F00) begin n_err++; $display("[TB] FAIL frame ip_zero: got %h want %h", obs_ipz, 64'h7F00); end
    n_cmp++; if (obs_ov !== 64'h7F80) begin n_err++; $display("[TB] FAIL frame out_valid: got %h want %h", obs_ov, 64'h7F80); end
    n_cmp++; if (obs_of !== 64'h80) begin n_err++; $display("[TB] FAIL frame out_first: got %h want %h", obs_of, 64'h80); end
    n_cmp++; if (obs_ol !== 64'h4000) begin n_err++; $display("[TB] FAIL frame out_last: got %h want %h", obs_ol, 64'h4000); end
    n_cmp++; if (obs_fe !== 64'h0) begin n_err++; $display("[TB] FAIL frame frame_err: got %h want 0", obs_fe); end
    n_cmp++; if (obs_stage[5] !== 9'd13 || obs_bf[5] !== 3'b001) begin
      n_err++; $display("[TB] FAIL frame stage@5: got %0d/%b want 13/001", obs_stage[5], obs_bf[5]); end
    n_cmp++; if (obs_stage[10] !== 9'd304 || obs_bf[10] !== 3'b010) begin
      n_err++; $display("[TB] FAIL frame stage@10: got %0d/%b want 304/010", obs_stage[10], obs_bf[10]); end
    n_cmp++; if (obs_stage[20] !== 9'd0) begin n_err++; $display("[TB] FAIL frame stage@20: got %0d want 0", obs_stage[20]); end
  endtask

  task automatic test_gaps();
    do_reset();
    run_trace(64'h7C7, 64'h400, 32);
    n_cmp++; if (obs_adv !== 64'h3FFC7) begin n_err++; $display("[TB] FAIL gaps adv: got %h want %h", obs_adv, 64'h3FFC7); end
    n_cmp++; if (obs_ipz !== 64'h3F800) begin n_err++; $display("[TB] FAIL gaps ip_zero: got %h want %h", obs_ipz, 64'h3F800); end
    n_cmp++; if (obs_ov !== 64'h3FC00) begin n_err++; $display("[TB] FAIL gaps out_valid: got %h want %h", obs_ov, 64'h3FC00); end
    n_cmp++; if (obs_of !== 64'h400 || obs_ol !== 64'h20000) begin
      n_err++; $display("[TB] FAIL gaps first/last: got %h/%h want 400/20000", obs_of, obs_ol); end
    n_cmp++; if (obs_fe !== 64'h0) begin n_err++; $display("[TB] FAIL gaps frame_err: got %h want 0", obs_fe); end
    for (int c = 3; c <= 5; c++) begin
      n_cmp++; if (obs_stage[c] !== 9'd3) begin n_err++; $display("[TB] FAIL gaps stage frozen@%0d: got %0d want 3", c, obs_stage[c]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_trace(64'hFFFF, 64'h8080, 32);
    n_cmp++; if (obs_adv !== 64'h7FFFFF) begin n_err++; $display("[TB] FAIL b2b adv: got %h want %h", obs_adv, 64'h7FFFFF); end
    n_cmp++; if (obs_ipz !== 64'h7F0000) begin n_err++; $display("[TB] FAIL b2b ip_zero: got %h want %h", obs_ipz, 64'h7F0000); end
    n_cmp++; if (obs_ov !== 64'h7FFF80) begin n_err++; $display("[TB] FAIL b2b out_valid: got %h want %h", obs_ov, 64'h7FFF80); end
    n_cmp++; if (obs_of !== 64'h8080) begin n_err++; $display("[TB] FAIL b2b out_first: got %h want %h", obs_of, 64'h8080); end
    n_cmp++; if (obs_ol !== 64'h404000) begin n_err++; $display("[TB] FAIL b2b out_last: got %h want %h", obs_ol, 64'h404000); end
  endtask

  task automatic test_drain_rejoin();
    do_reset();
    run_trace(64'h3FC0FF, 64'h200080, 40);
    n_cmp++; if (obs_adv !== 64'h1FFFFFFF) begin n_err++; $display("[TB] FAIL rejoin adv: got %h want %h", obs_adv, 64'h1FFFFFFF); end
    n_cmp++; if (obs_ipz !== 64'h1FC03F00) begin n_err++; $display("[TB] FAIL rejoin ip_zero: got %h want %h", obs_ipz, 64'h1FC03F00); end
    n_cmp++; if (obs_ov !== 64'h1FE07F80) begin n_err++; $display("[TB] FAIL rejoin out_valid: got %h want %h", obs_ov, 64'h1FE07F80); end
    n_cmp++; if (obs_of !== 64'h200080 || obs_ol !== 64'h10004000) begin
      n_err++; $display("[TB] FAIL rejoin first/last: got %h/%h want 200080/10004000", obs_of, obs_ol); end
  endtask

  task automatic test_early_last();
    do_reset();
    run_trace(64'h3FC01F, 64'h200010, 40);
    n_cmp++; if (obs_fe !== 64'h10) begin n_err++; $display("[TB] FAIL early frame_err: got %h want %h", obs_fe, 64'h10); end
    n_cmp++; if (obs_adv !== 64'h1FFFCFFF) begin n_err++; $display("[TB] FAIL early adv: got %h want %h", obs_adv, 64'h1FFFCFFF); end
    n_cmp++; if (obs_ipz !== 64'h1FC00FE0) begin n_err++; $display("[TB] FAIL early ip_zero: got %h want %h", obs_ipz, 64'h1FC00FE0); end
    n_cmp++; if (obs_ov !== 64'h1FE00F80) begin n_err++; $display("[TB] FAIL early out_valid: got %h want %h", obs_ov, 64'h1FE00F80); end
    n_cmp++; if (obs_of !== 64'h200080 || obs_ol !== 64'h10000800) begin
      n_err++; $display("[TB] FAIL early first/last: got %h/%h want 200080/10000800", obs_of, obs_ol); end
  endtask

  task automatic test_missing_last();
    do_reset();
    run_trace(64'hFF, 64'h0, 32);
    n_cmp++; if (obs_fe !== 64'h80) begin n_err++; $display("[TB] FAIL nolast frame_err: got %h want %h", obs_fe, 64'h80); end
    n_cmp++; if (obs_ol !== 64'h4000 || obs_ipz !== 64'h7F00) begin
      n_err++; $display("[TB] FAIL nolast last/ip_zero: got %h/%h want 4000/7f00", obs_ol, obs_ipz); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    run_trace(64'hFF, 64'h80, 10);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.adv, bus.ip_zero, bus.out_valid, bus.in_ready} !== 4'b0) begin
      n_err++; $display("[TB] FAIL drain reset flags: got %b want 0000", {bus.adv, bus.ip_zero, bus.out_valid, bus.in_ready}); end
    n_cmp++; if (bus.stage_cnt !== 9'd0) begin n_err++; $display("[TB] FAIL drain reset stage: got %0d want 0", bus.stage_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_trace(64'h0, 64'h0, 20);
    n_cmp++; if (obs_ov !== 64'h0 || obs_adv !== 64'h0) begin
      n_err++; $display("[TB] FAIL post-reset idle: got ov=%h adv=%h want 0/0", obs_ov, obs_adv); end
    run_trace(64'hFF, 64'h80, 32);
    n_cmp++; if (obs_ov !== 64'h7F80) begin n_err++; $display("[TB] FAIL post-reset frame out_valid: got %h want %h", obs_ov, 64'h7F80); end
  endtask

`ifdef SEQ_FRAME_CNT_EN
  task automatic test_frame_cnt();
    do_reset();
    n_cmp++; if (bus.frame_cnt !== 16'd0) begin n_err++; $display("[TB] FAIL frame_cnt reset: got %0d want 0", bus.frame_cnt); end
    run_trace(64'hFFFFFF, 64'h808080, 40);
    n_cmp++; if (bus.frame_cnt !== 16'd3) begin n_err++; $display("[TB] FAIL frame_cnt: got %0d want 3", bus.frame_cnt); end
  endtask
`endif

  // Test sequence.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    test_reset();
    test_single_frame();
    test_gaps();
    test_back_to_back();
    test_drain_rejoin();
    test_early_last();
    test_missing_last();
    test_reset_in_drain();
`ifdef SEQ_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
